// File: rtl/portgroup_regf_mst.sv
`default_nettype none
// ============================================================================
// Module      : portgroup_regf_mst
// Description : Command-driven initiator for the regf mem_* access port.
//               One register access per beat, auto-incrementing bursts,
//               per-beat response channel.
//               Optional macro PORTGROUP_REGF_MST_ERRABORT_EN ends a burst
//               on the first beat reporting mem_err_i.
// Revision    : 1.0 - initial release
// ============================================================================
module portgroup_regf_mst #(
    parameter int addr_width_p = 13,
    parameter int data_width_p = 32,
    parameter int len_width_p  = 4
) (
    input  logic                    main_clk_i,
    input  logic                    main_rst_an_i,

    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_wena_i,
    input  logic [addr_width_p-1:0] req_addr_i,
    input  logic [data_width_p-1:0] req_wdata_i,
    input  logic [len_width_p-1:0]  req_len_i,

    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [data_width_p-1:0] rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_last_o,

    output logic                    mem_ena_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    output logic                    mem_wena_o,
    output logic [data_width_p-1:0] mem_wdata_o,
    input  logic [data_width_p-1:0] mem_rdata_i,
    input  logic                    mem_err_i
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_acc  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_rsp  = 2'd3;

    localparam logic [addr_width_p-1:0] c_addr_one = addr_width_p'(1);
    localparam logic [len_width_p-1:0]  c_beat_one = len_width_p'(1);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [addr_width_p-1:0] r_addr;
    logic                    r_wena;
    logic [data_width_p-1:0] r_wdata;
    logic [len_width_p-1:0]  r_len;
    logic [len_width_p-1:0]  r_beat;
    logic                    r_req_ready;
    logic                    r_mem_ena;
    logic                    r_rsp_valid;
    logic [data_width_p-1:0] r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_rsp_last;

    logic                    w_accept;
    logic                    w_hshake;
    logic                    w_abort;
    logic                    w_last_beat;

`ifdef PORTGROUP_REGF_MST_ERRABORT_EN
    assign w_abort = mem_err_i;
`else
    assign w_abort = 1'b0;
`endif

    // r_req_ready is high exactly when the FSM sits in IDLE
    assign w_accept    = r_req_ready & req_valid_i;
    assign w_hshake    = r_rsp_valid & rsp_ready_i;
    assign w_last_beat = (r_beat == r_len) | w_abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_state_nxt = c_st_acc;
            c_st_acc:  w_state_nxt = c_st_wait;
            c_st_wait: w_state_nxt = c_st_rsp;
            c_st_rsp: begin
                if (w_hshake) begin
                    w_state_nxt = r_rsp_last ? c_st_idle : c_st_acc;
                end
            end
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Strobes are decoded from the next state so every output leaves a flop
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            r_state     <= c_st_idle;
            r_req_ready <= 1'b0;
            r_mem_ena   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == c_st_idle);
            r_mem_ena   <= (w_state_nxt == c_st_acc);
            r_rsp_valid <= (w_state_nxt == c_st_rsp);
        end
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            r_addr  <= '0;
            r_wena  <= 1'b0;
            r_wdata <= '0;
            r_len   <= '0;
            r_beat  <= '0;
        end else if (r_state == c_st_idle && w_accept) begin
            r_addr  <= req_addr_i;
            r_wena  <= req_wena_i;
            r_wdata <= req_wdata_i;
            r_len   <= req_len_i;
            r_beat  <= '0;
        end else if (r_state == c_st_rsp && w_hshake && !r_rsp_last) begin
            // Address rolls over naturally at the top of the word space
            r_addr  <= r_addr + c_addr_one;
            r_beat  <= r_beat + c_beat_one;
        end
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else if (r_state == c_st_wait) begin
            r_rsp_rdata <= r_wena ? '0 : mem_rdata_i;
            r_rsp_err   <= mem_err_i;
            r_rsp_last  <= w_last_beat;
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_last_o  = r_rsp_last;
    assign mem_ena_o   = r_mem_ena;
    assign mem_addr_o  = r_addr;
    assign mem_wena_o  = r_wena;
    assign mem_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_portgroup_regf_mst.sv
`default_nettype none
// ============================================================================
// Module      : tb_portgroup_regf_mst
// Description : Scoreboard bench for portgroup_regf_mst with a regf responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_portgroup_regf_mst;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_wena_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic [LW-1:0] req_len_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_last_o;
    logic          mem_ena_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_wena_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_err_i = 1'b0;

    always #5 clk = ~clk;

    portgroup_regf_mst #(
        .addr_width_p (AW),
        .data_width_p (DW),
        .len_width_p  (LW)
    ) dut (
        .main_clk_i    (clk),
        .main_rst_an_i (rst_n),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_wena_i    (req_wena_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_len_i     (req_len_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_last_o    (rsp_last_o),
        .mem_ena_o     (mem_ena_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wena_o    (mem_wena_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_err_i     (mem_err_i)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          last;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wena;
        logic [DW-1:0] wdata;
    } acc_t;

    rsp_t          exp_rsp[$];
    acc_t          exp_acc[$];
    logic [DW-1:0] regf_mem  [DEPTH];
    logic [DW-1:0] model_mem [DEPTH];
    bit            err_map   [DEPTH];

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;   // 0 random, 1 always ready, 2 never ready

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a command is the list of beats addr, addr+1, ... mod 2^AW
    task automatic build_expect(input logic w, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d, input logic [LW-1:0] l);
        logic [AW-1:0] a;
        rsp_t r;
        acc_t x;
        for (int i = 0; i <= int'(l); i++) begin
            a = a0 + AW'(i);
            x.addr = a; x.wena = w; x.wdata = d;
            exp_acc.push_back(x);
            r.rdata = w ? '0 : model_mem[a];
            if (w) model_mem[a] = d;
            r.err  = err_map[a];
            r.last = (i == int'(l));
`ifdef PORTGROUP_REGF_MST_ERRABORT_EN
            if (r.err) r.last = 1'b1;
`endif
            exp_rsp.push_back(r);
            if (r.last) break;
        end
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [LW-1:0] l);
        bit accepted;
        accepted = 1'b0;
        build_expect(w, a, d, l);
        @(posedge clk); #2;
        req_valid_i = 1'b1; req_wena_i = w; req_addr_i = a; req_wdata_i = d; req_len_i = l;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (req_ready_o) begin accepted = 1'b1; break; end
        end
        chk("req_accept", 64'(accepted), 1);
        @(posedge clk); #1;
        req_valid_i = 1'b0; req_wena_i = $urandom_range(0, 1);
        req_addr_i = AW'($urandom); req_wdata_i = $urandom; req_len_i = LW'($urandom);
    endtask

    task automatic drain();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (exp_rsp.size() == 0 && req_ready_o) break;
        end
        chk("drain_rsp_left", 64'(exp_rsp.size()), 0);
        chk("drain_acc_left", 64'(exp_acc.size()), 0);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready_i = ($urandom_range(0, 3) != 0);
            1:       rsp_ready_i = 1'b1;
            default: rsp_ready_i = 1'b0;
        endcase
    end

    // Regf responder: data/err valid the cycle after a strobe, junk otherwise
    bit            pend = 0;
    bit            prev_ena = 0;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_rd;
    acc_t          got_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0; prev_ena = 0;
        end else begin
            pend = mem_ena_o;
            if (mem_ena_o) begin
                chk("mem_ena_single_cycle", 64'(prev_ena), 0);
                chk("no_access_while_rsp", 64'(rsp_valid_o), 0);
                chk("access_expected", 64'(exp_acc.size() != 0), 1);
                if (exp_acc.size() != 0) begin
                    got_acc = exp_acc.pop_front();
                    chk("acc_addr", 64'(mem_addr_o), 64'(got_acc.addr));
                    chk("acc_wena", 64'(mem_wena_o), 64'(got_acc.wena));
                    if (got_acc.wena) chk("acc_wdata", 64'(mem_wdata_o), 64'(got_acc.wdata));
                end
                pend_addr = mem_addr_o;
                pend_rd   = regf_mem[mem_addr_o];
                if (mem_wena_o) regf_mem[mem_addr_o] = mem_wdata_o;
            end
            prev_ena = mem_ena_o;
        end
    end

    always @(posedge clk) begin
        #1;
        if (pend && rst_n) begin
            mem_rdata_i = pend_rd;
            mem_err_i   = err_map[pend_addr];
        end else begin
            mem_rdata_i = $urandom;
            mem_err_i   = 1'($urandom_range(0, 1));
        end
    end

    // Response monitor
    rsp_t          got_rsp;
    bit            stall_prev = 0;
    bit            hs_nonlast = 0;
    bit            hs_last = 0;
    logic [DW-1:0] hold_rdata;
    logic          hold_err;
    logic          hold_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0; hs_nonlast = 0; hs_last = 0;
        end else begin
            if (hs_nonlast) chk("next_access_after_handshake", 64'(mem_ena_o), 1);
            if (hs_last)    chk("idle_after_last", 64'(req_ready_o), 1);
            if (stall_prev) begin
                chk("stall_valid", 64'(rsp_valid_o), 1);
                chk("stall_rdata", 64'(rsp_rdata_o), 64'(hold_rdata));
                chk("stall_err",   64'(rsp_err_o),   64'(hold_err));
                chk("stall_last",  64'(rsp_last_o),  64'(hold_last));
            end
            stall_prev = 0; hs_nonlast = 0; hs_last = 0;
            if (rsp_valid_o) begin
                if (rsp_ready_i) begin
                    chk("rsp_expected", 64'(exp_rsp.size() != 0), 1);
                    if (exp_rsp.size() != 0) begin
                        got_rsp = exp_rsp.pop_front();
                        chk("rsp_rdata", 64'(rsp_rdata_o), 64'(got_rsp.rdata));
                        chk("rsp_err",   64'(rsp_err_o),   64'(got_rsp.err));
                        chk("rsp_last",  64'(rsp_last_o),  64'(got_rsp.last));
                    end
                    hs_last    = rsp_last_o;
                    hs_nonlast = !rsp_last_o;
                end else begin
                    stall_prev = 1;
                    hold_rdata = rsp_rdata_o; hold_err = rsp_err_o; hold_last = rsp_last_o;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [DW-1:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            regf_mem[i] = v; model_mem[i] = v; err_map[i] = 1'b0;
        end

        // Reset state
        #17;
        chk("rst_req_ready", 64'(req_ready_o), 0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 0);
        chk("rst_mem_ena",   64'(mem_ena_o),   0);
        chk("rst_rsp_rdata", 64'(rsp_rdata_o), 0);
        chk("rst_mem_addr",  64'(mem_addr_o),  0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(req_ready_o), 1);

        // Single read with exact latency
        rdy_mode = 1;
        regf_mem[13'h010] = 32'hDEADBEEF; model_mem[13'h010] = 32'hDEADBEEF;
        issue(1'b0, 13'h010, 32'h0, 4'd0);
        @(negedge clk);
        chk("lat_ena_e1", 64'(mem_ena_o), 1);
        chk("lat_wena_e1", 64'(mem_wena_o), 0);
        @(negedge clk);
        chk("lat_ena_e2", 64'(mem_ena_o), 0);
        chk("lat_valid_e2", 64'(rsp_valid_o), 0);
        @(negedge clk);
        chk("lat_valid_e3", 64'(rsp_valid_o), 1);
        drain();

        // Write fill, then read back
        issue(1'b1, 13'h100, 32'hA5A5A5A5, 4'd3);
        issue(1'b0, 13'h100, 32'h0, 4'd3);
        drain();

        // Wrap at the top of the address space
        issue(1'b0, 13'h1FFF, 32'h0, 4'd1);
        drain();

        // Backpressure on beat 0
        rdy_mode = 2;
        issue(1'b0, 13'h050, 32'h0, 4'd1);
        for (int n = 0; n < 20 && !rsp_valid_o; n++) @(negedge clk);
        chk("bp_valid_seen", 64'(rsp_valid_o), 1);
        repeat (10) @(negedge clk);
        rdy_mode = 1;
        drain();

        // Error on beat 1 of a 4-beat read
        err_map[13'h201] = 1'b1;
        issue(1'b0, 13'h200, 32'h0, 4'd3);
        drain();
        err_map[13'h201] = 1'b0;

        // Reset during WAIT of beat 2
        issue(1'b0, 13'h300, 32'h0, 4'd3);
        cnt = 0;
        for (int n = 0; n < 40 && cnt < 3; n++) begin
            @(negedge clk);
            if (mem_ena_o) cnt++;
        end
        chk("rst_burst_reached_beat2", 64'(cnt), 3);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 64'(req_ready_o), 0);
        chk("midrst_rsp_valid", 64'(rsp_valid_o), 0);
        chk("midrst_mem_ena",   64'(mem_ena_o),   0);
        chk("midrst_rsp_last",  64'(rsp_last_o),  0);
        chk("midrst_rsp_err",   64'(rsp_err_o),   0);
        exp_rsp.delete(); exp_acc.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_ready", 64'(req_ready_o), 1);
        chk("postrst_valid", 64'(rsp_valid_o), 0);
        repeat (3) begin
            @(negedge clk);
            chk("postrst_no_access", 64'(mem_ena_o), 0);
        end

        // Randomized commands with random backpressure and error map
        for (int i = 0; i < DEPTH; i++) err_map[i] = ($urandom_range(0, 7) == 0);
        rdy_mode = 0;
        for (int k = 0; k < 40; k++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'(DEPTH - 1 - $urandom_range(0, 4)) : AW'($urandom);
            issue(1'($urandom_range(0, 1)), a, $urandom, LW'($urandom));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
